// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit sequencer that runs on the 8-bit ALU:
// op codes, flag bit positions, sequencer states and op legality.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SHR = 4'h0,
    OP_SHL = 4'h1,
    OP_INC = 4'h4,
    OP_DEC = 4'h5,
    OP_ADD = 4'h6,
    OP_NOT = 4'h8,
    OP_AND = 4'h9,
    OP_OR  = 4'ha,
    OP_MOV = 4'hb
  } alu_op_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_P0   = 3'd1,
    SEQ_P1   = 3'd2,
    SEQ_FIX  = 3'd3,
    SEQ_DONE = 3'd4
  } seq_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'ha, 4'hb: is_legal_op = 1'b1;
      default:                                              is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Runs one 16-bit operation as two or three byte passes through the parent's
// 8-bit ALU, chaining the carry between bytes, then reports result and flags.
//
// state | meaning
// IDLE  | ready for a request; ALU driven with MOV of zero
// P0    | first byte pass (low byte, high byte for SHR)
// P1    | second byte pass, op may depend on the P0 carry
// FIX   | carry fix-up on the P1 byte (ADD/SHL/SHR only)
// DONE  | one-cycle done pulse; result/flags valid
module alu_wide_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic [3:0]  op_in,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [3:0]  flags_in,
  output logic        ready_out,
  output logic        done_out,
  output logic [15:0] result_out,
  output logic [3:0]  flags_out,
  output logic [7:0]  alu_a_out,
  output logic [7:0]  alu_b_out,
  output logic [3:0]  alu_op_out,
  output logic [3:0]  alu_status_out,
  input  logic [7:0]  alu_result_in,
  input  logic [3:0]  alu_status_in
);

  localparam logic [2:0] S_IDLE = SEQ_IDLE;
  localparam logic [2:0] S_P0   = SEQ_P0;
  localparam logic [2:0] S_P1   = SEQ_P1;
  localparam logic [2:0] S_FIX  = SEQ_FIX;
  localparam logic [2:0] S_DONE = SEQ_DONE;

  logic [2:0]  state;
  logic [3:0]  op_r;
  logic [15:0] a_r, b_r;
  logic [3:0]  flags_r;
  logic [7:0]  p0_r, p1_r;
  logic        c0_r, c1_r;

  logic        two_operand, need_fix;
  logic        fin_c1, fin_cfix, fin_c, fin_v;
  logic [15:0] fin_r;
  logic [3:0]  fin_flags;
  logic        unused_status;

  assign unused_status = ^alu_status_in[2:0];
  assign ready_out     = (state == S_IDLE);
  assign done_out      = (state == S_DONE);
  assign two_operand   = (op_r == OP_ADD) || (op_r == OP_AND) || (op_r == OP_OR);
  assign need_fix      = c0_r && ((op_r == OP_ADD) || (op_r == OP_SHL) || (op_r == OP_SHR));

  always_comb begin
    alu_a_out      = 8'h00;
    alu_b_out      = 8'h00;
    alu_op_out     = OP_MOV;
    alu_status_out = 4'h0;
    case (state)
      S_P0: begin
        alu_status_out = flags_r;
        alu_op_out     = op_r;
        alu_a_out      = (op_r == OP_SHR) ? a_r[15:8] : a_r[7:0];
        alu_b_out      = two_operand ? b_r[7:0] : 8'h00;
      end
      S_P1: begin
        alu_status_out = flags_r;
        alu_a_out      = (op_r == OP_SHR) ? a_r[7:0] : a_r[15:8];
        alu_b_out      = two_operand ? b_r[15:8] : 8'h00;
        // INC/DEC propagate the low-byte carry/borrow by choosing the high-byte op
        if (op_r == OP_INC)      alu_op_out = c0_r ? OP_INC : OP_MOV;
        else if (op_r == OP_DEC) alu_op_out = c0_r ? OP_MOV : OP_DEC;
        else                     alu_op_out = op_r;
      end
      S_FIX: begin
        alu_status_out = flags_r;
        alu_a_out      = p1_r;
        if (op_r == OP_ADD) begin
          alu_op_out = OP_INC;
        end else begin
          alu_op_out = OP_OR;
          alu_b_out  = (op_r == OP_SHR) ? 8'h80 : 8'h01;
        end
      end
      default: ;
    endcase
  end

  // Final byte is whatever the ALU returns in the last pass (P1 or FIX).
  always_comb begin
    fin_c1   = (state == S_P1) ? alu_status_in[FLAG_C] : c1_r;
    fin_cfix = (state == S_FIX) && alu_status_in[FLAG_C];
    fin_r    = (op_r == OP_SHR) ? {p0_r, alu_result_in} : {alu_result_in, p0_r};
    fin_c    = flags_r[FLAG_C];
    fin_v    = flags_r[FLAG_V];
    case (op_r)
      OP_ADD: begin
        fin_c = fin_c1 | fin_cfix;
        fin_v = (a_r[15] & b_r[15] & ~fin_r[15]) | (~a_r[15] & ~b_r[15] & fin_r[15]);
      end
      OP_INC: begin
        fin_c = c0_r & fin_c1;
        fin_v = ~a_r[15] & fin_r[15];
      end
      OP_DEC: begin
        fin_c = (a_r != 16'h0000);
        fin_v = a_r[15] & ~fin_r[15];
      end
      OP_SHL: fin_c = a_r[15];
      OP_SHR: fin_c = a_r[0];
      default: ;
    endcase
    fin_flags = {fin_c, fin_r[15], fin_v, (fin_r == 16'h0000)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_r       <= 4'h0;
      a_r        <= 16'h0000;
      b_r        <= 16'h0000;
      flags_r    <= 4'h0;
      p0_r       <= 8'h00;
      p1_r       <= 8'h00;
      c0_r       <= 1'b0;
      c1_r       <= 1'b0;
      result_out <= 16'h0000;
      flags_out  <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_in) begin
            op_r    <= op_in;
            a_r     <= a_in;
            b_r     <= b_in;
            flags_r <= flags_in;
            if (is_legal_op(op_in)) begin
              state <= S_P0;
            end else begin
              state      <= S_DONE;
              result_out <= 16'h0000;
              flags_out  <= 4'h0;
            end
          end
        end
        S_P0: begin
          p0_r  <= alu_result_in;
          c0_r  <= alu_status_in[FLAG_C];
          state <= S_P1;
        end
        S_P1: begin
          p1_r <= alu_result_in;
          c1_r <= alu_status_in[FLAG_C];
          if (need_fix) begin
            state <= S_FIX;
          end else begin
            result_out <= fin_r;
            flags_out  <= fin_flags;
            state      <= S_DONE;
          end
        end
        S_FIX: begin
          result_out <= fin_r;
          flags_out  <= fin_flags;
          state      <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
